button_debounce: RTL and testbench
==================================

Name: button_debounce

Overview:
- Input-side counterpart to the board's LED output path.
- Takes NUM_BTN raw, asynchronous push-button levels from board pins and synchronises each one into the clk domain.
- Debounces each button and produces clean level, press/release pulses, long-press pulses and a per-button press counter for downstream logic.
- Sits directly behind the top-level button pins, before any user control logic.

Parameters:
- NUM_BTN, 4: number of independent button channels (>=1).
- DEBOUNCE_CYCLES, 250000: consecutive clk cycles a new level must persist before acceptance (>=1).
- LONG_CYCLES, 25000000: clk cycles a debounced press must be held before btn_long fires (>=1).
- CNT_W, 4: width of each per-button press counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- btn_in  input  NUM_BTN  raw asynchronous button levels, 1 = pressed.
- btn_level  output  NUM_BTN  debounced level per button.
- btn_press  output  NUM_BTN  1-cycle pulse on debounced 0->1.
- btn_release  output  NUM_BTN  1-cycle pulse on debounced 1->0.
- btn_long  output  NUM_BTN  1-cycle pulse when a press has been held LONG_CYCLES.
- press_count  output  NUM_BTN*CNT_W  packed press counters; button i occupies [i*CNT_W +: CNT_W].

Behaviour:
- Reset is synchronous, active-high, on clk. It clears everything:
  - sync flops, debounced state, debounce counter, hold counter and press_count to 0;
  - btn_level, btn_press, btn_release and btn_long to 0.
- Channels are fully independent. There is no cross-channel interaction and no priority.
- Synchroniser: 2-flop chain per bit (s1 <= btn_in; s2 <= s1). Only s2 is used downstream.
- Debounce, per channel, each edge:
  - If s2 == state: db_cnt <= 0.
  - Else if db_cnt == DEBOUNCE_CYCLES-1: state <= s2; db_cnt <= 0.
  - Else: db_cnt <= db_cnt+1.
- Debounce counter width is $clog2(DEBOUNCE_CYCLES+1). The counter never exceeds DEBOUNCE_CYCLES-1.
- Latency: a btn_in change stable from before edge 1 updates state at edge 2+DEBOUNCE_CYCLES.
- Glitch rejection: any return of s2 to state before the count completes restarts the count from 0.
- btn_level = state, registered, with no extra delay.
- btn_press and btn_release are registered with the state update. Each is high for exactly the one cycle following the edge at which state changes.
- Hold counter, per channel:
  - Cleared while state == 0.
  - While state == 1, increments each edge, saturating at LONG_CYCLES.
- btn_long is high for one cycle after the edge at which the hold counter goes from LONG_CYCLES-1 to LONG_CYCLES.
  - Exactly one btn_long per press, however long the button is held.
  - Release before that edge gives no btn_long.
- press_count[i] increments by 1 on every btn_press[i] event and wraps modulo 2^CNT_W. It is not cleared by release, only by reset.
- Reset during debounce or hold discards the partial count. No pulse is emitted; the next press is debounced from scratch.
- A bouncing input that never stays stable for DEBOUNCE_CYCLES produces no outputs.

Decomposition:
- Shared package debounce_pkg holds default constants DEBOUNCE_CYCLES_DEF, LONG_CYCLES_DEF and CNT_W_DEF.
- One natural sub-module, debounce_chan: a single-bit synchroniser, debounce counter, hold counter, pulse generation and press counter.
- button_debounce instantiates NUM_BTN copies of debounce_chan in a generate loop and packs their outputs.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=10, NUM_BTN=4, CNT_W=4):
- Reset asserted 3 cycles with btn_in=4'hF -> all outputs 0 throughout. After release of reset, btn_level=4'hF exactly 6 edges later and btn_press=4'hF for one cycle.
- btn_in[0] 0->1 held stable -> btn_level[0]=1 after edge 6, btn_press[0] one cycle, press_count[0]=1. btn_long[0] fires one cycle after edge 16, once only, while held for 50 cycles.
- btn_in[1] toggled high for 3 cycles then low, repeated 5 times -> btn_level[1], btn_press[1] and press_count[1] stay 0.
- btn_in[2] pressed 6 cycles then released -> btn_press[2], then btn_release[2] one cycle after the edge 6 edges after release. No btn_long[2].
- 17 clean presses on btn_in[3] -> press_count[3] reads 1 (wrap past 15 to 0, then 1). Other channels unaffected.
- Reset asserted at cycle 3 of a 4-cycle debounce on btn_in[0] -> no btn_press[0]. After reset deasserts, with the input still high, btn_press[0] occurs 6 edges later.

Source files
------------

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared defaults for the push-button debounce path
package debounce_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 250000;
    localparam int LONG_CYCLES_DEF     = 25000000;
    localparam int CNT_W_DEF           = 4;

endpackage

// File: rtl/debounce_chan.sv
// rtl/debounce_chan.sv - one button: synchroniser, debounce, hold timer, pulses, press counter
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_btn,
    output logic             o_level,
    output logic             o_press,
    output logic             o_release,
    output logic             o_long,
    output logic [CNT_W-1:0] o_count
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic              r_s1;
    logic              r_s2;
    logic              r_state;
    logic [DB_W-1:0]   r_db_cnt;
    logic [HOLD_W-1:0] r_hold;
    logic              r_press;
    logic              r_release;
    logic              r_long;
    logic [CNT_W-1:0]  r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_state   <= 1'b0;
            r_db_cnt  <= '0;
            r_hold    <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_count   <= '0;
        end else begin
            r_s1      <= i_btn;
            r_s2      <= r_s1;
            r_press   <= 1'b0;
            r_release <= 1'b0;

            // Any return to the accepted level restarts the qualification window.
            if (r_s2 == r_state) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_state   <= r_s2;
                r_db_cnt  <= '0;
                r_press   <= r_s2;
                r_release <= ~r_s2;
                if (r_s2) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end

            // Saturating hold timer guarantees a single long pulse per press.
            if (!r_state) begin
                r_hold <= '0;
            end else if (r_hold != HOLD_MAX) begin
                r_hold <= r_hold + HOLD_W'(1);
            end
            r_long <= r_state && (r_hold == HOLD_LAST);
        end
    end

    assign o_level   = r_state;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;
    assign o_count   = r_count;

endmodule

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - NUM_BTN independent debounced button channels
module button_debounce
    import debounce_pkg::*;
#(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_BTN-1:0]       btn_in,
    output logic [NUM_BTN-1:0]       btn_level,
    output logic [NUM_BTN-1:0]       btn_press,
    output logic [NUM_BTN-1:0]       btn_release,
    output logic [NUM_BTN-1:0]       btn_long,
    output logic [NUM_BTN*CNT_W-1:0] press_count
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .CNT_W           (CNT_W)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .i_btn     (btn_in[i]),
            .o_level   (btn_level[i]),
            .o_press   (btn_press[i]),
            .o_release (btn_release[i]),
            .o_long    (btn_long[i]),
            .o_count   (press_count[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - directed bench for button_debounce
module tb_button_debounce;

    localparam int NB = 4;
    localparam int CW = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [NB-1:0]    btn_in;
    logic [NB-1:0]    btn_level;
    logic [NB-1:0]    btn_press;
    logic [NB-1:0]    btn_release;
    logic [NB-1:0]    btn_long;
    logic [NB*CW-1:0] press_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    button_debounce #(
        .NUM_BTN         (NB),
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (10),
        .CNT_W           (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long),
        .press_count (press_count)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset  = 1'b1;
        btn_in = 4'hF;
        @(negedge clk);

        for (int c = 0; c < 3; c++) begin
            step();
            chk("rst_pulses", {16'h0, btn_level, btn_press, btn_release, btn_long}, 32'h0);
            chk("rst_count", {16'h0, press_count}, 32'h0);
        end

        // All four pressed out of reset: accepted 6 edges later, long 10 edges after that.
        reset = 1'b0;
        for (int e = 1; e <= 18; e++) begin
            step();
            chk("all_level", {28'h0, btn_level}, (e >= 6) ? 32'hF : 32'h0);
            chk("all_press", {28'h0, btn_press}, (e == 6) ? 32'hF : 32'h0);
            chk("all_long", {28'h0, btn_long}, (e == 16) ? 32'hF : 32'h0);
        end
        chk("all_count", {16'h0, press_count}, 32'h1111);

        btn_in = 4'h0;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk("all_release", {28'h0, btn_release}, (e == 6) ? 32'hF : 32'h0);
        end
        chk("all_level_off", {28'h0, btn_level}, 32'h0);

        btn_in = 4'h1;
        for (int e = 1; e <= 50; e++) begin
            step();
            chk("b0_level", {28'h0, btn_level}, (e >= 6) ? 32'h1 : 32'h0);
            chk("b0_press", {28'h0, btn_press}, (e == 6) ? 32'h1 : 32'h0);
            chk("b0_long", {28'h0, btn_long}, (e == 16) ? 32'h1 : 32'h0);
        end
        chk("b0_count", {16'h0, press_count}, 32'h1112);
        btn_in = 4'h0;
        for (int e = 0; e < 10; e++) step();
        chk("b0_off", {28'h0, btn_level}, 32'h0);

        // Bounce shorter than the debounce window must never be accepted.
        for (int r = 0; r < 5; r++) begin
            btn_in = 4'h2;
            for (int e = 0; e < 3; e++) begin
                step();
                chk("b1_bounce_lvl", {28'h0, btn_level}, 32'h0);
                chk("b1_bounce_prs", {28'h0, btn_press}, 32'h0);
            end
            btn_in = 4'h0;
            for (int e = 0; e < 3; e++) begin
                step();
                chk("b1_bounce_lvl", {28'h0, btn_level}, 32'h0);
                chk("b1_bounce_prs", {28'h0, btn_press}, 32'h0);
            end
        end
        for (int e = 0; e < 8; e++) step();
        chk("b1_count", {16'h0, press_count}, 32'h1112);

        btn_in = 4'h4;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (e == 6) btn_in = 4'h0;
            chk("b2_level", {28'h0, btn_level}, (e >= 6 && e < 12) ? 32'h4 : 32'h0);
            chk("b2_press", {28'h0, btn_press}, (e == 6) ? 32'h4 : 32'h0);
            chk("b2_release", {28'h0, btn_release}, (e == 12) ? 32'h4 : 32'h0);
            chk("b2_long", {28'h0, btn_long}, 32'h0);
        end
        chk("b2_count", {16'h0, press_count}, 32'h1212);

        reset = 1'b1;
        step();
        step();
        chk("rst2_count", {16'h0, press_count}, 32'h0);
        reset = 1'b0;

        // 17 presses wrap the 4-bit counter past 15 back to 1.
        for (int p = 0; p < 17; p++) begin
            btn_in = 4'h8;
            for (int e = 0; e < 8; e++) step();
            btn_in = 4'h0;
            for (int e = 0; e < 8; e++) step();
            if (p == 14) chk("b3_count15", {16'h0, press_count}, 32'hF000);
            if (p == 15) chk("b3_count_wrap", {16'h0, press_count}, 32'h0000);
        end
        chk("b3_count", {16'h0, press_count}, 32'h1000);

        btn_in = 4'h1;
        for (int e = 1; e <= 4; e++) begin
            step();
            chk("rst_mid_press", {28'h0, btn_press}, 32'h0);
        end
        reset = 1'b1;
        for (int e = 0; e < 2; e++) begin
            step();
            chk("rst_mid_hold", {28'h0, btn_press | btn_level}, 32'h0);
        end
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk("rst_mid_after", {28'h0, btn_press}, (e == 6) ? 32'h1 : 32'h0);
        end
        chk("rst_mid_count", {16'h0, press_count}, 32'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
